// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the IF stage: reset vector, stall, prioritised
// branch/jump/exception redirects, misaligned-target trapping and stall-held redirects.
module pc_sequencer #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned RESET_VECTOR = 100,
  parameter int unsigned EXC_VECTOR   = 32'h80,
  parameter int unsigned INCR         = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exception,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next_seq,
  output logic             flush,
  output logic [WIDTH-1:0] epc,
  output logic             misaligned,
  output logic             pending
);

  localparam logic [WIDTH-1:0] RST_PC  = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] EXC_PC  = WIDTH'(EXC_VECTOR);
  localparam logic [WIDTH-1:0] STEP    = WIDTH'(INCR);
  localparam logic [WIDTH-1:0] ZERO_PC = {WIDTH{1'b0}};

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             flush_q, flush_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             mis_q, mis_d;
  logic [WIDTH-1:0] held_tgt_q, held_tgt_d;
  logic             held_exc_q, held_exc_d;

  logic             req_valid_s;
  logic             req_exc_s;
  logic             req_mis_s;
  logic [WIDTH-1:0] req_tgt_s;
  logic [WIDTH-1:0] req_epc_s;
  logic             take_new_s;

  function automatic logic is_misaligned(input logic [WIDTH-1:0] target);
    return (target[1:0] != 2'b00);
  endfunction

  // Resolve this cycle's winning request and turn misaligned targets into exceptions.
  always_comb begin
    req_valid_s = 1'b0;
    req_exc_s   = 1'b0;
    req_mis_s   = 1'b0;
    req_tgt_s   = pc_q;
    req_epc_s   = epc_q;
    if (exception) begin
      req_valid_s = 1'b1;
      req_exc_s   = 1'b1;
      req_tgt_s   = EXC_PC;
      req_epc_s   = pc_q;
    end else if (branch_taken) begin
      req_valid_s = 1'b1;
      if (is_misaligned(branch_target)) begin
        req_exc_s = 1'b1;
        req_mis_s = 1'b1;
        req_tgt_s = EXC_PC;
        req_epc_s = branch_target;
      end else begin
        req_tgt_s = branch_target;
      end
    end else if (jump) begin
      req_valid_s = 1'b1;
      if (is_misaligned(jump_target)) begin
        req_exc_s = 1'b1;
        req_mis_s = 1'b1;
        req_tgt_s = EXC_PC;
        req_epc_s = jump_target;
      end else begin
        req_tgt_s = jump_target;
      end
    end else begin
      req_valid_s = 1'b0;
    end
  end

  // A held exception is never displaced by a later non-exception request.
  assign take_new_s = req_valid_s && !(held_exc_q && !req_exc_s);

  // Next-state logic for the RUN/HOLD sequencer.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flush_d    = 1'b0;
    held_tgt_d = held_tgt_q;
    held_exc_d = held_exc_q;
    mis_d      = req_mis_s;
    epc_d      = req_exc_s ? req_epc_s : epc_q;
    case (state_q)
      ST_RUN: begin
        if (!stall) begin
          if (req_valid_s) begin
            pc_d    = req_tgt_s;
            flush_d = 1'b1;
          end else begin
            pc_d = pc_q + STEP;
          end
        end else if (req_valid_s) begin
          held_tgt_d = req_tgt_s;
          held_exc_d = req_exc_s;
          state_d    = ST_HOLD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (stall) begin
          if (take_new_s) begin
            held_tgt_d = req_tgt_s;
            held_exc_d = req_exc_s;
          end else begin
            held_tgt_d = held_tgt_q;
          end
        end else begin
          pc_d       = take_new_s ? req_tgt_s : held_tgt_q;
          flush_d    = 1'b1;
          held_tgt_d = ZERO_PC;
          held_exc_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      default: begin
        state_d    = ST_RUN;
        held_tgt_d = ZERO_PC;
        held_exc_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset discards any held redirect.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RST_PC;
      flush_q    <= 1'b0;
      epc_q      <= ZERO_PC;
      mis_q      <= 1'b0;
      held_tgt_q <= ZERO_PC;
      held_exc_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      epc_q      <= epc_d;
      mis_q      <= mis_d;
      held_tgt_q <= held_tgt_d;
      held_exc_q <= held_exc_d;
    end
  end

  assign pc          = pc_q;
  assign pc_next_seq = pc_q + STEP;
  assign flush       = flush_q;
  assign epc         = epc_q;
  assign misaligned  = mis_q;
  assign pending     = (state_q == ST_HOLD);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer: a 32-bit instance driven from
// a vector table and an 8-bit instance exercising wrap and reset-while-pending.
module tb_pc_sequencer;

  logic        clock;
  int          checks;
  int          failures;

  logic        reset, stall, branch_taken, jump, exception;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc, pc_next_seq, epc;
  logic        flush, misaligned, pending;

  logic        reset8, stall8, branch8, jump8, exc8;
  logic [7:0]  btgt8, jtgt8;
  logic [7:0]  pc8, pcn8, epc8;
  logic        flush8, mis8, pend8;

  pc_sequencer dut (
    .clock(clock), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .exception(exception),
    .pc(pc), .pc_next_seq(pc_next_seq), .flush(flush), .epc(epc),
    .misaligned(misaligned), .pending(pending)
  );

  pc_sequencer #(.WIDTH(8), .RESET_VECTOR(32'hFC)) dut8 (
    .clock(clock), .reset(reset8), .stall(stall8),
    .branch_taken(branch8), .branch_target(btgt8),
    .jump(jump8), .jump_target(jtgt8), .exception(exc8),
    .pc(pc8), .pc_next_seq(pcn8), .flush(flush8), .epc(epc8),
    .misaligned(mis8), .pending(pend8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic        ex;
    logic [31:0] e_pc;
    logic        e_flush;
    logic [31:0] e_epc;
    logic        e_mis;
    logic        e_pend;
  } vec_t;

  localparam int NVEC = 28;
  vec_t vecs [NVEC];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s step=%0d actual=0x%0h expected=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive8(input logic r, input logic s, input logic j, input logic [7:0] jt);
    @(negedge clock);
    reset8 = r; stall8 = s; jump8 = j; jtgt8 = jt;
    branch8 = 1'b0; btgt8 = 8'h00; exc8 = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; exception = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0;
    reset8 = 1'b1; stall8 = 1'b0; branch8 = 1'b0; jump8 = 1'b0; exc8 = 1'b0;
    btgt8 = 8'h00; jtgt8 = 8'h00;

    //           rst   stl   br    bt          jp    jt          ex    pc          fl    epc         mis   pend
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'd100,    1'b0, 32'h0,      1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'd104,    1'b0, 32'h0,      1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'd108,    1'b0, 32'h0,      1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h200,    1'b1, 32'h300,    1'b0, 32'h200,    1'b1, 32'h0,      1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'h204,    1'b0, 32'h0,      1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b1, 32'h400,    1'b0, 32'h204,    1'b0, 32'h0,      1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'h204,    1'b0, 32'h0,      1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'h204,    1'b0, 32'h0,      1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'h400,    1'b1, 32'h0,      1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 32'h402,    1'b0, 32'h80,     1'b1, 32'h402,    1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'h84,     1'b0, 32'h402,    1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 32'h10C,    1'b0, 32'h10C,    1'b1, 32'h402,    1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b0, 32'h0,      1'b1, 32'h10C,    1'b0, 32'h10C,    1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h500,    1'b0, 32'h0,      1'b0, 32'h10C,    1'b0, 32'h10C,    1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'h80,     1'b1, 32'h10C,    1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'h84,     1'b0, 32'h10C,    1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b1, 32'h600,    1'b0, 32'h84,     1'b0, 32'h10C,    1'b0, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 32'h700,    1'b0, 32'h0,      1'b0, 32'h700,    1'b1, 32'h10C,    1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 32'h701,    1'b0, 32'h0,      1'b0, 32'h700,    1'b0, 32'h701,    1'b1, 1'b1};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b1, 32'h800,    1'b0, 32'h700,    1'b0, 32'h701,    1'b0, 1'b1};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'h80,     1'b1, 32'h701,    1'b0, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 1'b1, 32'h900,    1'b0, 32'h0,      1'b1, 32'h80,     1'b1, 32'h80,     1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'h84,     1'b0, 32'h80,     1'b0, 1'b0};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 32'h1000,   1'b0, 32'h1000,   1'b1, 32'h80,     1'b0, 1'b0};
    vecs[24] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 32'h2000,   1'b0, 32'h2000,   1'b1, 32'h80,     1'b0, 1'b0};
    vecs[25] = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b1, 32'h3000,   1'b0, 32'h2000,   1'b0, 32'h80,     1'b0, 1'b1};
    vecs[26] = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h3000,   1'b0, 32'd100,    1'b0, 32'h0,      1'b0, 1'b0};
    vecs[27] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'd104,    1'b0, 32'h0,      1'b0, 1'b0};

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clock);
      reset         = vecs[i].rst;
      stall         = vecs[i].stl;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].bt;
      jump          = vecs[i].jp;
      jump_target   = vecs[i].jt;
      exception     = vecs[i].ex;
      @(posedge clock);
      #1;
      check("pc",          i, pc,                   vecs[i].e_pc);
      check("pc_next_seq", i, pc_next_seq,          vecs[i].e_pc + 32'd4);
      check("flush",       i, {31'b0, flush},       {31'b0, vecs[i].e_flush});
      check("epc",         i, epc,                  vecs[i].e_epc);
      check("misaligned",  i, {31'b0, misaligned},  {31'b0, vecs[i].e_mis});
      check("pending",     i, {31'b0, pending},     {31'b0, vecs[i].e_pend});
    end

    // 8-bit instance: wrap past 0xFF, then reset while a redirect is held.
    drive8(1'b1, 1'b0, 1'b0, 8'h00);
    check("w8_reset_pc",  100, {24'b0, pc8},   32'hFC);
    check("w8_next_seq",  100, {24'b0, pcn8},  32'h00);
    drive8(1'b0, 1'b0, 1'b0, 8'h00);
    check("w8_wrap_pc",   101, {24'b0, pc8},   32'h00);
    check("w8_wrap_fl",   101, {31'b0, flush8}, 32'h0);
    drive8(1'b0, 1'b1, 1'b1, 8'h40);
    check("w8_hold_pc",   102, {24'b0, pc8},   32'h00);
    check("w8_hold_pend", 102, {31'b0, pend8}, 32'h1);
    drive8(1'b1, 1'b1, 1'b0, 8'h00);
    check("w8_rst_pc",    103, {24'b0, pc8},   32'hFC);
    check("w8_rst_pend",  103, {31'b0, pend8}, 32'h0);
    drive8(1'b0, 1'b0, 1'b0, 8'h00);
    check("w8_after_pc",  104, {24'b0, pc8},   32'h00);
    check("w8_after_fl",  104, {31'b0, flush8}, 32'h0);
    drive8(1'b0, 1'b0, 1'b1, 8'h41);
    check("w8_mis_pc",    105, {24'b0, pc8},   32'h80);
    check("w8_mis_epc",   105, {24'b0, epc8},  32'h41);
    check("w8_mis_flag",  105, {31'b0, mis8},  32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
